counter4_cout: RTL and testbench

- Free-running 4-bit binary up-counter with a carry-out flag.
- Increments by one on every rising clock edge and wraps modulo 16.
- COUT flags the terminal count, i.e. the cycle whose increment produces a carry.
- Leaf timing/sequencing primitive; used as a tick source and cascadable via COUT.

---
 rtl/counter4_pkg.sv | 17 +
 rtl/counter4_cout_if.sv | 31 +++
 rtl/counter4_inc.sv | 26 ++
 rtl/counter4_cout.sv | 53 +++++
 tb/tb_counter4_cout.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter4_pkg.sv
// Shared widths, types and constants for the counter4_cout tick counter.
// Optional clock-enable build is selected by COUNTER4_CE_EN (see counter4_cout.sv).
package counter4_pkg;

    localparam int COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;

    localparam count_t COUNT_MAX = '1;
    localparam count_t COUNT_RST = '0;

    // True when a value of the default width sits at terminal count.
    function automatic logic is_terminal(input count_t value);
        return (value == COUNT_MAX);
    endfunction

endpackage : counter4_pkg

// File: rtl/counter4_cout_if.sv
// Count/carry bundle of counter4_cout; CE exists only when COUNTER4_CE_EN is defined.
// master = the counter itself, slave = whoever consumes the count and carry.
interface counter4_cout_if
    import counter4_pkg::*;
#(
    parameter int WIDTH = COUNT_W
);

    logic [WIDTH-1:0] O;
    logic             COUT;
`ifdef COUNTER4_CE_EN
    logic             CE;
`endif

    modport master (
`ifdef COUNTER4_CE_EN
        input  CE,
`endif
        output O,
        output COUT
    );

    modport slave (
`ifdef COUNTER4_CE_EN
        output CE,
`endif
        input  O,
        input  COUT
    );

endinterface : counter4_cout_if

// File: rtl/counter4_inc.sv
// Combinational WIDTH-bit +1 incrementer built as an explicit ripple of half adders,
// so the carry out of the top bit is the terminal-count flag.
module counter4_inc
    import counter4_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_half_add
            assign sum[gi]      = a[gi] ^ carry[gi];
            assign carry[gi+1]  = a[gi] & carry[gi];
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule : counter4_inc

// File: rtl/counter4_cout.sv
// Free-running WIDTH-bit up-counter with combinational carry-out for cascading.
// Define COUNTER4_CE_EN to add a clock enable (CE) that gates both counting and COUT.
module counter4_cout
    import counter4_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    counter4_cout_if.master   bus
);

    logic [WIDTH-1:0] count_q = '0;  // power-up value, matches the reset value
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_cout;

    counter4_inc #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a    (count_q),
        .sum  (inc_sum),
        .cout (inc_cout)
    );

    always_comb begin
        count_d = inc_sum;
`ifdef COUNTER4_CE_EN
        if (!bus.CE) begin
            count_d = count_q;
        end
`endif
    end

    // Reset takes priority over both increment and enable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.O = count_q;

`ifdef COUNTER4_CE_EN
    // Carry only when this stage actually wraps, so a cascaded stage stays in step.
    assign bus.COUT = inc_cout & bus.CE;
`else
    assign bus.COUT = inc_cout;
`endif

endmodule : counter4_cout

// File: tb/tb_counter4_cout.sv
// Directed-vector bench for counter4_cout; covers the CE build when COUNTER4_CE_EN is defined.
module tb_counter4_cout;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    counter4_cout_if bus ();

    counter4_cout dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_powerup();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL powerup_t0: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d powerup_t0 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        for (int i = 1; i <= 2; i++) begin
            step();
            vectors++;
            if ({bus.O, bus.COUT} !== {4'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL powerup_edge%0d: O=%0d COUT=%b expected O=%0d COUT=0",
                         i, bus.O, bus.COUT, i);
            end
            $display("vec %0d powerup_edge%0d O=%0d COUT=%b", vectors, i, bus.O, bus.COUT);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_o;
        logic       exp_c;
        RESET = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            vectors++;
            if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold%0d: O=%0d COUT=%b expected O=0 COUT=0", i, bus.O, bus.COUT);
            end
            $display("vec %0d reset_hold%0d O=%0d COUT=%b", vectors, i, bus.O, bus.COUT);
        end
        RESET = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_o = 4'(i % 16);
            exp_c = (i == 15);
            vectors++;
            if ({bus.O, bus.COUT} !== {exp_o, exp_c}) begin
                miscompares++;
                $display("FAIL count_seq%0d: O=%0d COUT=%b expected O=%0d COUT=%b",
                         i, bus.O, bus.COUT, exp_o, exp_c);
            end
            $display("vec %0d count_seq%0d O=%0d COUT=%b", vectors, i, bus.O, bus.COUT);
        end
    endtask

    // Enters with O=0.
    task automatic test_wrap();
        repeat (14) step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd14, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_at14: O=%0d COUT=%b expected O=14 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d wrap_at14 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_at15: O=%0d COUT=%b expected O=15 COUT=1", bus.O, bus.COUT);
        end
        $display("vec %0d wrap_at15 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_to0: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d wrap_to0 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
    endtask

    // Enters with O=0.
    task automatic test_reset_mid();
        repeat (9) step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd9, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_at9: O=%0d COUT=%b expected O=9 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d mid_at9 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d mid_reset O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_release: O=%0d COUT=%b expected O=1 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d mid_release O=%0d COUT=%b", vectors, bus.O, bus.COUT);
    endtask

    // Enters with O=1.
    task automatic test_reset_terminal();
        repeat (14) step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL term_at15: O=%0d COUT=%b expected O=15 COUT=1", bus.O, bus.COUT);
        end
        $display("vec %0d term_at15 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL term_reset: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d term_reset O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL term_release: O=%0d COUT=%b expected O=1 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d term_release O=%0d COUT=%b", vectors, bus.O, bus.COUT);
    endtask

`ifdef COUNTER4_CE_EN
    // Enters with O=1, CE=1.
    task automatic test_ce();
        repeat (4) step();
        bus.CE = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if ({bus.O, bus.COUT} !== {4'd5, 1'b0}) begin
                miscompares++;
                $display("FAIL ce_hold%0d: O=%0d COUT=%b expected O=5 COUT=0", i, bus.O, bus.COUT);
            end
            $display("vec %0d ce_hold%0d O=%0d COUT=%b", vectors, i, bus.O, bus.COUT);
        end
        bus.CE = 1'b1;
        repeat (10) step();
        bus.CE = 1'b0;
        #1;
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL ce_gate_cout: O=%0d COUT=%b expected O=15 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d ce_gate_cout O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL ce_hold15: O=%0d COUT=%b expected O=15 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d ce_hold15 O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        bus.CE = 1'b1;
        #1;
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL ce_cout_on: O=%0d COUT=%b expected O=15 COUT=1", bus.O, bus.COUT);
        end
        $display("vec %0d ce_cout_on O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL ce_wrap: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d ce_wrap O=%0d COUT=%b", vectors, bus.O, bus.COUT);
        step();
        bus.CE = 1'b0;
        RESET  = 1'b1;
        step();
        RESET  = 1'b0;
        bus.CE = 1'b1;
        vectors++;
        if ({bus.O, bus.COUT} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL ce_reset_prio: O=%0d COUT=%b expected O=0 COUT=0", bus.O, bus.COUT);
        end
        $display("vec %0d ce_reset_prio O=%0d COUT=%b", vectors, bus.O, bus.COUT);
    endtask
`endif

    initial begin
`ifdef COUNTER4_CE_EN
        bus.CE = 1'b1;
`endif
        #1;
        test_powerup();
        test_reset();
        test_wrap();
        test_reset_mid();
        test_reset_terminal();
`ifdef COUNTER4_CE_EN
        test_ce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_counter4_cout
